// File: rtl/output_switch_ctrl.sv
// ---------------------------------------------------------------------------
// output_switch_ctrl
//
// Chooses which of the four tuner TS channels feeds the ASI output mux.
// Requests come from the front-panel switch or from an SPI register write.
// A switch waits for a packet boundary (P_SYNC rising edge) on the target
// channel, or it is forced after a timeout. Each applied switch is followed
// by a RESET_LEN-cycle downstream flush pulse.
//
// Ports:
//   CLK                 system clock
//   RST                 asynchronous, active-high reset
//   SPI_ADDRESS[7:0]    address of the last SPI transfer
//   SPI_DATA[7:0]       data of the last SPI transfer
//                       (bit 7 = SPI mode, bits 1:0 = channel)
//   RISING_SS           one-cycle strobe at the end of an SPI transfer
//   SW[1:0]             front-panel channel switch, asynchronous to CLK
//   P_SYNC_BUS[3:0]     per-channel packet sync, already in the CLK domain
//   SELECT[1:0]         channel index to the output mux
//   RESET_ON_CHANGE_OUT downstream flush pulse after each applied switch
//   BUSY                high while a switch is pending or being applied
//   MODE_SPI            1 = SPI controls the selection, 0 = SW controls it
//   FORCED              sticky; last switch was applied by timeout
//
// ADDR is normally overridden at integration with `ADDR_OUT_SELECT from
// defines.v; the default here only keeps the module standalone.
// ---------------------------------------------------------------------------
module output_switch_ctrl #(
    parameter logic [7:0] ADDR         = 8'h20,
    parameter int         SW_STABLE    = 1024,
    parameter int         SYNC_TIMEOUT = 65535,
    parameter int         RESET_LEN    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SPI_ADDRESS,
    input  logic [7:0] SPI_DATA,
    input  logic       RISING_SS,
    input  logic [1:0] SW,
    input  logic [3:0] P_SYNC_BUS,
    output logic [1:0] SELECT,
    output logic       RESET_ON_CHANGE_OUT,
    output logic       BUSY,
    output logic       MODE_SPI,
    output logic       FORCED
);

    localparam int STAB_W = $clog2(SW_STABLE + 1);
    localparam int TMO_W  = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam int HOLD_W = (RESET_LEN > 1) ? $clog2(RESET_LEN) : 1;

    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(SW_STABLE);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SYNC_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_APPLY = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Switch input conditioning
    logic [1:0]        sw_meta_q,   sw_meta_d;
    logic [1:0]        sw_sync_q,   sw_sync_d;
    logic [1:0]        sw_last_q,   sw_last_d;
    logic [STAB_W-1:0] stab_cnt_q,  stab_cnt_d;
    logic [1:0]        stable_sw_q, stable_sw_d;

    // Packet-sync edge detection
    logic [3:0]        psync_prev_q, psync_prev_d;

    // Control FSM and its registered outputs
    state_t            state_q,    state_d;
    logic [1:0]        target_q,   target_d;
    logic [TMO_W-1:0]  tmo_cnt_q,  tmo_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pend_vld_q, pend_vld_d;
    logic [1:0]        pend_ch_q,  pend_ch_d;
    logic [1:0]        select_q,   select_d;
    logic              roc_q,      roc_d;
    logic              busy_q,     busy_d;
    logic              mode_spi_q, mode_spi_d;
    logic              forced_q,   forced_d;

    // Combinational helpers
    logic       sw_changed;
    logic       sw_req;
    logic       spi_wr;
    logic       req_vld;
    logic [1:0] req_ch;
    logic [3:0] psync_rise;
    logic       nxt_vld;
    logic [1:0] nxt_ch;

    // Only the mode bit and the channel field of SPI_DATA are meaningful.
    logic unused_spi_bits;
    assign unused_spi_bits = ^SPI_DATA[6:2];

    // -----------------------------------------------------------------------
    // Request sources: SW debounce and SPI decode
    // -----------------------------------------------------------------------
    always_comb begin
        sw_meta_d = SW;
        sw_sync_d = sw_meta_q;
        sw_last_d = sw_sync_q;

        // The stability counter restarts whenever the synchronised value moves.
        sw_changed = (sw_sync_q != sw_last_q);
        stab_cnt_d = stab_cnt_q;
        if (sw_changed) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end

        stable_sw_d = stable_sw_q;
        if (!sw_changed && (stab_cnt_q == STAB_MAX)) begin
            stable_sw_d = sw_last_q;
        end
        sw_req = (stable_sw_d != stable_sw_q) && !mode_spi_q;

        spi_wr     = RISING_SS && (SPI_ADDRESS == ADDR);
        mode_spi_d = spi_wr ? SPI_DATA[7] : mode_spi_q;

        // An SPI write outranks a SW request in the same cycle. Handing control
        // back to the switch re-issues whatever the switch currently shows.
        req_vld = 1'b0;
        req_ch  = 2'd0;
        if (spi_wr && SPI_DATA[7]) begin
            req_vld = 1'b1;
            req_ch  = SPI_DATA[1:0];
        end else if (spi_wr && mode_spi_q) begin
            req_vld = 1'b1;
            req_ch  = stable_sw_q;
        end else if (sw_req) begin
            req_vld = 1'b1;
            req_ch  = stable_sw_d;
        end

        psync_prev_d = P_SYNC_BUS;
        psync_rise   = P_SYNC_BUS & ~psync_prev_q;
    end

    // -----------------------------------------------------------------------
    // Switch sequencing FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        tmo_cnt_d  = tmo_cnt_q;
        hold_cnt_d = hold_cnt_q;
        pend_vld_d = pend_vld_q;
        pend_ch_d  = pend_ch_q;
        select_d   = select_q;
        roc_d      = roc_q;
        busy_d     = busy_q;
        forced_d   = forced_q;

        nxt_vld = req_vld || pend_vld_q;
        nxt_ch  = req_vld ? req_ch : pend_ch_q;

        case (state_q)
            S_IDLE: begin
                // A request for the channel already on air is dropped silently.
                if (req_vld && (req_ch != select_q)) begin
                    target_d  = req_ch;
                    tmo_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_WAIT;
                end
            end

            S_WAIT: begin
                // A fresh request restarts the wait and masks any sync edge
                // seen in the same cycle.
                if (req_vld) begin
                    target_d  = req_ch;
                    tmo_cnt_d = '0;
                end else if (psync_rise[target_q]) begin
                    forced_d = 1'b0;
                    state_d  = S_APPLY;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    forced_d = 1'b1;
                    state_d  = S_APPLY;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            S_APPLY: begin
                select_d   = target_q;
                roc_d      = 1'b1;
                hold_cnt_d = HOLD_LOAD;
                pend_vld_d = req_vld;
                pend_ch_d  = req_ch;
                state_d    = S_HOLD;
            end

            S_HOLD: begin
                // Requests during the flush pulse are parked; the latest wins.
                if (req_vld) begin
                    pend_vld_d = 1'b1;
                    pend_ch_d  = req_ch;
                end
                if (hold_cnt_q == '0) begin
                    roc_d      = 1'b0;
                    pend_vld_d = 1'b0;
                    if (nxt_vld && (nxt_ch != select_q)) begin
                        target_d  = nxt_ch;
                        tmo_cnt_d = '0;
                        state_d   = S_WAIT;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw_meta_q    <= 2'd0;
            sw_sync_q    <= 2'd0;
            sw_last_q    <= 2'd0;
            stab_cnt_q   <= '0;
            stable_sw_q  <= 2'd0;
            psync_prev_q <= 4'd0;
            state_q      <= S_IDLE;
            target_q     <= 2'd0;
            tmo_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            pend_vld_q   <= 1'b0;
            pend_ch_q    <= 2'd0;
            select_q     <= 2'd0;
            roc_q        <= 1'b0;
            busy_q       <= 1'b0;
            mode_spi_q   <= 1'b0;
            forced_q     <= 1'b0;
        end else begin
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
            sw_last_q    <= sw_last_d;
            stab_cnt_q   <= stab_cnt_d;
            stable_sw_q  <= stable_sw_d;
            psync_prev_q <= psync_prev_d;
            state_q      <= state_d;
            target_q     <= target_d;
            tmo_cnt_q    <= tmo_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            pend_vld_q   <= pend_vld_d;
            pend_ch_q    <= pend_ch_d;
            select_q     <= select_d;
            roc_q        <= roc_d;
            busy_q       <= busy_d;
            mode_spi_q   <= mode_spi_d;
            forced_q     <= forced_d;
        end
    end

    assign SELECT              = select_q;
    assign RESET_ON_CHANGE_OUT = roc_q;
    assign BUSY                = busy_q;
    assign MODE_SPI            = mode_spi_q;
    assign FORCED              = forced_q;

endmodule

// File: tb/tb_output_switch_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for output_switch_ctrl.
// Inputs are driven 1 ns after each rising edge and outputs are sampled at
// the same point, so every observed value reflects the preceding edge.
// ---------------------------------------------------------------------------
module tb_output_switch_ctrl;

    localparam logic [7:0] ADDR = 8'h20;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] SPI_ADDRESS;
    logic [7:0] SPI_DATA;
    logic       RISING_SS;
    logic [1:0] SW;
    logic [3:0] P_SYNC_BUS;
    logic [1:0] SELECT;
    logic       RESET_ON_CHANGE_OUT;
    logic       BUSY;
    logic       MODE_SPI;
    logic       FORCED;

    int n_checks = 0;
    int n_errors = 0;
    logic seen;

    output_switch_ctrl #(
        .ADDR         (ADDR),
        .SW_STABLE    (16),
        .SYNC_TIMEOUT (100),
        .RESET_LEN    (4)
    ) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .SPI_ADDRESS         (SPI_ADDRESS),
        .SPI_DATA            (SPI_DATA),
        .RISING_SS           (RISING_SS),
        .SW                  (SW),
        .P_SYNC_BUS          (P_SYNC_BUS),
        .SELECT              (SELECT),
        .RESET_ON_CHANGE_OUT (RESET_ON_CHANGE_OUT),
        .BUSY                (BUSY),
        .MODE_SPI            (MODE_SPI),
        .FORCED              (FORCED)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic spi_write(input logic [7:0] addr, input logic [7:0] data);
        SPI_ADDRESS = addr;
        SPI_DATA    = data;
        RISING_SS   = 1'b1;
        tick();
        RISING_SS   = 1'b0;
    endtask

    // Called right after the edge that enters APPLY: SELECT changes on the
    // next edge together with a flush pulse exactly four cycles long.
    task automatic pulse(input logic [1:0] sel, input string tag);
        tick();
        check({tag, "_select"}, 8'(SELECT), 8'(sel));
        check({tag, "_roc_first"}, 8'(RESET_ON_CHANGE_OUT), 8'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check({tag, "_roc_hold"}, 8'(RESET_ON_CHANGE_OUT), 8'd1);
        end
        tick();
        check({tag, "_roc_end"}, 8'(RESET_ON_CHANGE_OUT), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST         = 1'b1;
        SPI_ADDRESS = 8'h00;
        SPI_DATA    = 8'h00;
        RISING_SS   = 1'b0;
        SW          = 2'd0;
        P_SYNC_BUS  = 4'd0;
        repeat (3) tick();
        check("rst_select", 8'(SELECT), 8'd0);
        check("rst_roc",    8'(RESET_ON_CHANGE_OUT), 8'd0);
        check("rst_busy",   8'(BUSY), 8'd0);
        check("rst_mode",   8'(MODE_SPI), 8'd0);
        check("rst_forced", 8'(FORCED), 8'd0);
        RST = 1'b0;
        tick();

        // SW glitch shorter than the stability window raises nothing.
        SW = 2'd1;
        repeat (10) tick();
        SW = 2'd0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen = seen | BUSY;
        end
        check("sw_glitch_busy", 8'(seen), 8'd0);

        // SW held long enough becomes a request for channel 1.
        SW = 2'd1;
        repeat (40) tick();
        check("sw_req_busy",   8'(BUSY), 8'd1);
        check("sw_req_select", 8'(SELECT), 8'd0);
        P_SYNC_BUS = 4'b0010;
        tick();
        P_SYNC_BUS = 4'b0000;
        check("sw_apply_select_old", 8'(SELECT), 8'd0);
        pulse(2'd1, "sw");
        check("sw_busy_done", 8'(BUSY), 8'd0);
        check("sw_forced",    8'(FORCED), 8'd0);

        // SPI takes over and requests channel 2.
        spi_write(ADDR, 8'h82);
        SW = 2'd0;
        check("spi2_mode", 8'(MODE_SPI), 8'd1);
        check("spi2_busy", 8'(BUSY), 8'd1);
        spi_write(ADDR ^ 8'h01, 8'h01);
        repeat (8) tick();
        check("spi_other_addr_mode", 8'(MODE_SPI), 8'd1);
        P_SYNC_BUS = 4'b0100;
        tick();
        P_SYNC_BUS = 4'b0000;
        check("spi2_apply_select_old", 8'(SELECT), 8'd1);
        pulse(2'd2, "spi2");
        check("spi2_busy_done", 8'(BUSY), 8'd0);
        check("spi2_forced",    8'(FORCED), 8'd0);

        // Channel 3 silent: the switch is forced after the timeout.
        spi_write(ADDR, 8'h83);
        check("tmo_busy", 8'(BUSY), 8'd1);
        repeat (99) tick();
        check("tmo_wait_select", 8'(SELECT), 8'd2);
        check("tmo_wait_busy",   8'(BUSY), 8'd1);
        tick();
        check("tmo_apply_select_old", 8'(SELECT), 8'd2);
        pulse(2'd3, "tmo");
        check("tmo_forced",    8'(FORCED), 8'd1);
        check("tmo_busy_done", 8'(BUSY), 8'd0);

        // Reset in the middle of a pending switch clears everything at once.
        spi_write(ADDR, 8'h81);
        check("mid_busy_before", 8'(BUSY), 8'd1);
        #2;
        RST = 1'b1;
        #1;
        check("arst_select", 8'(SELECT), 8'd0);
        check("arst_roc",    8'(RESET_ON_CHANGE_OUT), 8'd0);
        check("arst_busy",   8'(BUSY), 8'd0);
        check("arst_mode",   8'(MODE_SPI), 8'd0);
        check("arst_forced", 8'(FORCED), 8'd0);
        repeat (3) tick();
        RST = 1'b0;
        P_SYNC_BUS = 4'b1111;
        tick();
        P_SYNC_BUS = 4'b0000;
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | BUSY | RESET_ON_CHANGE_OUT;
        end
        check("post_rst_idle", 8'(seen), 8'd0);
        check("post_rst_select", 8'(SELECT), 8'd0);

        // Request for the channel already selected is discarded.
        spi_write(ADDR, 8'h80);
        check("discard_mode", 8'(MODE_SPI), 8'd1);
        seen = BUSY;
        repeat (6) begin
            tick();
            seen = seen | BUSY | RESET_ON_CHANGE_OUT;
        end
        check("discard_quiet", 8'(seen), 8'd0);

        // Latest request wins; a request coincident with a sync edge masks it.
        spi_write(ADDR, 8'h81);
        check("lw_busy", 8'(BUSY), 8'd1);
        repeat (3) tick();
        P_SYNC_BUS = 4'b0010;
        spi_write(ADDR, 8'h83);
        P_SYNC_BUS = 4'b0000;
        tick();
        check("lw_coincident_edge_roc", 8'(RESET_ON_CHANGE_OUT), 8'd0);
        P_SYNC_BUS = 4'b0010;
        tick();
        P_SYNC_BUS = 4'b0000;
        tick();
        check("lw_old_edge_roc",    8'(RESET_ON_CHANGE_OUT), 8'd0);
        check("lw_old_edge_select", 8'(SELECT), 8'd0);
        P_SYNC_BUS = 4'b1000;
        tick();
        P_SYNC_BUS = 4'b0000;
        check("lw_apply_select_old", 8'(SELECT), 8'd0);
        pulse(2'd3, "lw");
        check("lw_forced",    8'(FORCED), 8'd0);
        check("lw_busy_done", 8'(BUSY), 8'd0);

        // A request during the flush pulse chains straight into a new wait.
        spi_write(ADDR, 8'h82);
        repeat (2) tick();
        P_SYNC_BUS = 4'b0100;
        tick();
        P_SYNC_BUS = 4'b0000;
        check("hold_apply_select_old", 8'(SELECT), 8'd3);
        tick();
        check("hold_select", 8'(SELECT), 8'd2);
        check("hold_roc1",   8'(RESET_ON_CHANGE_OUT), 8'd1);
        spi_write(ADDR, 8'h81);
        check("hold_roc2", 8'(RESET_ON_CHANGE_OUT), 8'd1);
        tick();
        check("hold_roc3", 8'(RESET_ON_CHANGE_OUT), 8'd1);
        tick();
        check("hold_roc4", 8'(RESET_ON_CHANGE_OUT), 8'd1);
        tick();
        check("hold_roc_end",    8'(RESET_ON_CHANGE_OUT), 8'd0);
        check("hold_busy_kept",  8'(BUSY), 8'd1);
        check("hold_select_kept", 8'(SELECT), 8'd2);
        repeat (2) tick();
        check("hold_wait_busy", 8'(BUSY), 8'd1);
        P_SYNC_BUS = 4'b0010;
        tick();
        P_SYNC_BUS = 4'b0000;
        pulse(2'd1, "chain");
        check("chain_busy_done", 8'(BUSY), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
